// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity frame checker.
// Holds the receive FSM state encoding and the parity-sense constants
// used by parity_frame_checker and frame_reduce.
package parity_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY
    } state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/frame_reduce.sv
// Combinational reductions over a received data word.
// Ports:
//   data       in  DATA_W  word to reduce
//   exp_parity out 1       parity bit the transmitter should have sent
//   all_zero   out 1       every data bit is 0
//   all_one    out 1       every data bit is 1
module frame_reduce
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = PAR_EVEN
) (
    input  logic [DATA_W-1:0] data,
    output logic              exp_parity,
    output logic              all_zero,
    output logic              all_one
);

    assign exp_parity = (ODD_PARITY == PAR_ODD) ? ~^data : ^data;
    assign all_zero   = ~|data;
    assign all_one    = &data;

endmodule

// File: rtl/parity_frame_checker.sv
// Bit-serial frame receiver: collects DATA_W data bits LSB first followed by
// one parity bit, checks the parity and reports per-frame reduction flags.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   frame_start  pulse that (re)starts a frame; aborts any frame in progress
//   bit_valid    bit_in carries a data or parity bit this cycle
//   bit_in       serial bit
//   out_valid    one-cycle pulse when a frame completes
//   data_out     last completed data word (held between frames)
//   parity_err   last completed frame had a parity mismatch
//   all_zero     data_out is all zeros
//   all_one      data_out is all ones
//   err_count    saturating count of frames received with a parity error
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = PAR_EVEN,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              all_zero,
    output logic              all_one,
    output logic [CNT_W-1:0]  err_count
);

    localparam int              CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   bit_mask;
    logic                exp_par;
    logic                red_zero;
    logic                red_one;
    logic                bad_par;

    frame_reduce #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_reduce (
        .data       (shift),
        .exp_parity (exp_par),
        .all_zero   (red_zero),
        .all_one    (red_one)
    );

    // The shift register is cleared at every frame start and each position is
    // written exactly once, so OR-ing in a positioned bit is equivalent to a
    // per-bit write without a variable-width index.
    assign bit_mask = {{(DATA_W-1){1'b0}}, bit_in} << cnt;
    assign bad_par  = (bit_in != exp_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shift      <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            all_zero   <= 1'b0;
            all_one    <= 1'b0;
            err_count  <= '0;
        end else begin
            out_valid <= 1'b0;
            // frame_start wins over bit_valid in every state: the bit that
            // arrives alongside it is dropped.
            if (frame_start) begin
                shift <= '0;
                cnt   <= '0;
                state <= S_DATA;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_DATA: begin
                        if (bit_valid) begin
                            shift <= shift | bit_mask;
                            cnt   <= cnt + CW'(1);
                            if (cnt == LAST_BIT) begin
                                state <= S_PARITY;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_valid) begin
                            data_out   <= shift;
                            parity_err <= bad_par;
                            all_zero   <= red_zero;
                            all_one    <= red_one;
                            out_valid  <= 1'b1;
                            if (bad_par && (err_count != CNT_MAX)) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Bit-serial frame receiver and parity checker. It is the receive end of a link whose transmitter appends a reduction-XOR parity bit to each data word.
- Deserialises DATA_W data bits (LSB first) plus one parity bit.
- Checks the parity bit, reports per-frame reduction flags (all-zero, all-one) and keeps a saturating error count.
- Sits between a serial line front-end and any byte-wide consumer.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32).
- ODD_PARITY, 0, 0 = even parity (parity bit = ^data); 1 = odd parity (parity bit = ~^data).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: asynchronous, active-low.
- frame_start  input  1  one-cycle pulse marking the start of a frame; data bits begin on the following cycles.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data or parity bit.
- out_valid  output  1  one-cycle pulse: frame complete; result outputs updated.
- data_out  output  DATA_W  received data word.
- parity_err  output  1  received parity bit differs from the expected parity.
- all_zero  output  1  ~|data_out.
- all_one  output  1  &data_out.
- err_count  output  CNT_W  count of frames with parity_err = 1, saturating.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, bit counter = 0, shift register = 0.
  - out_valid, data_out, parity_err, all_zero, all_one and err_count all = 0.
- States: IDLE, DATA, PARITY (encoding from the package).
- IDLE:
  - bit_valid is ignored.
  - frame_start: clear shift register and counter, go to DATA.
  - frame_start together with bit_valid: that bit is dropped.
- DATA:
  - On each bit_valid, bit_in is written into shift register position [cnt] (LSB first) and cnt increments.
  - When the DATA_W-th bit is accepted, go to PARITY.
  - bit_valid = 0 cycles stall; there is no timeout.
- PARITY:
  - On bit_valid, sample the parity bit p and compute expected = ^shift (even) or ~^shift (odd).
  - At that clock edge, register:
    - data_out = shift
    - parity_err = (p != expected)
    - all_zero = ~|shift
    - all_one = &shift
  - out_valid = 1 for exactly the next cycle. Latency: out_valid high one cycle after the parity-bit edge.
  - Return to IDLE.
- frame_start in DATA or PARITY:
  - Aborts the frame: clear shift register and counter, stay in or enter DATA.
  - No out_valid, no err_count change.
  - frame_start has priority over a simultaneous bit_valid; that bit is dropped.
- Outputs between frames: data_out and the flags hold their values until the next completed frame. out_valid is a pulse only.
- err_count:
  - Increments on the same edge that sets parity_err = 1.
  - Holds at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- Reset mid-frame: partial frame discarded, no out_valid. After rst_n rises, the block waits in IDLE for frame_start.
- Width rules: counter width is $clog2(DATA_W+1). Parity and flags use full-width reduction over DATA_W.

Decomposition:
- Package parity_pkg:
  - State encoding localparams ST_IDLE, ST_DATA, ST_PARITY.
  - PAR_EVEN / PAR_ODD constants.
- One sub-module, frame_reduce (combinational):
  - Input: DATA_W word and ODD_PARITY.
  - Outputs: expected parity, all_zero, all_one.
  - Instantiated once on the shift register.
- FSM, shift register and counters stay in the top module.

Test Plan:
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1), parity bit 0, even parity -> out_valid one cycle after the parity edge; data_out = 0xA5, parity_err = 0, all_zero = 0, all_one = 0, err_count = 0.
- Frame 0xA5, parity bit 1 -> parity_err = 1, err_count = 1. Frame 0x00, parity bit 0 -> all_zero = 1. Frame 0xFF, parity bit 0 -> all_one = 1, parity_err = 0.
- ODD_PARITY = 1: frame 0x01, parity bit 0 -> parity_err = 0. Same frame, parity bit 1 -> parity_err = 1.
- Abort: frame_start, 3 bits, frame_start, full frame 0x3C with parity 0, with bit_valid gaps inserted -> exactly one out_valid; data_out = 0x3C, parity_err = 0.
- Saturation: 260 consecutive bad-parity frames with CNT_W = 8 -> err_count = 255, holds at 255.
- Reset: assert rst_n = 0 after 5 data bits -> all outputs 0 asynchronously. Bits sent before any frame_start -> no out_valid. Next full frame 0x5A, parity 0 -> data_out = 0x5A, parity_err = 0.
